// File: rtl/sensor_debounce_if.sv
// ---------------------------------------------------------------------------
// sensor_debounce_if
//   Signal bundle between the raw beam sensors / status logic and the
//   sensor_debounce block. Clock and reset are kept as plain ports.
//
//   a_raw, b_raw  raw beam sensors (1 = beam broken), asynchronous to clk
//   fault_clr     single-cycle pulse, clears both stuck flags
//   a, b          debounced levels
//   a_rise/a_fall one-cycle edge pulses for a
//   b_rise/b_fall one-cycle edge pulses for b
//   a_stuck       sticky flag: a held 1 for STUCK_CYCLES
//   b_stuck       sticky flag: b held 1 for STUCK_CYCLES
//
//   master: the side that drives the sensors (bench / pad logic)
//   slave : the debounce block
// ---------------------------------------------------------------------------
interface sensor_debounce_if;
    logic a_raw;
    logic b_raw;
    logic fault_clr;
    logic a;
    logic b;
    logic a_rise;
    logic a_fall;
    logic b_rise;
    logic b_fall;
    logic a_stuck;
    logic b_stuck;

    modport master (
        output a_raw, b_raw, fault_clr,
        input  a, b, a_rise, a_fall, b_rise, b_fall, a_stuck, b_stuck
    );

    modport slave (
        input  a_raw, b_raw, fault_clr,
        output a, b, a_rise, a_fall, b_rise, b_fall, a_stuck, b_stuck
    );
endinterface

// File: rtl/sensor_debounce.sv
// ---------------------------------------------------------------------------
// sensor_debounce
//   Conditions the two raw beam-sensor inputs of the parking entrance.
//   Each channel is synchronised (2 flops), debounced, edge-detected and
//   watched by a stuck-at-1 monitor. Channels are identical and independent.
//
//   clk    system clock, all state on rising edge
//   reset  asynchronous, active-low reset
//   bus    sensor_debounce_if.slave (raw inputs, fault_clr, clean levels,
//          edge pulses, stuck flags)
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// sensor_debounce_ch
//   One sensor channel.
//
//   raw_i        raw sensor, asynchronous to clk
//   fault_clr_i  clears the stuck counter and flag
//   clean_o      debounced level
//   rise_o       one-cycle pulse in the first cycle clean_o shows 1
//   fall_o       one-cycle pulse in the first cycle clean_o shows 0
//   stuck_o      sticky: clean_o held 1 for STUCK_CYCLES cycles
// ---------------------------------------------------------------------------
module sensor_debounce_ch #(
    parameter int DEB_CYCLES   = 16,
    parameter int DEB_W        = 5,
    parameter int STUCK_CYCLES = 1000000,
    parameter int STUCK_W      = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    input  logic fault_clr_i,
    output logic clean_o,
    output logic rise_o,
    output logic fall_o,
    output logic stuck_o
);
    localparam logic [DEB_W-1:0]   DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [STUCK_W-1:0] STUCK_MAX = STUCK_W'(STUCK_CYCLES);

    // sync_q[0] is the metastability catcher, sync_q[1] the only tap used
    logic [1:0]         sync_q;
    logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
    logic               clean_q, clean_d;
    logic               rise_q, rise_d;
    logic               fall_q, fall_d;
    logic [STUCK_W-1:0] stk_cnt_q, stk_cnt_d;
    logic               stuck_q, stuck_d;

    always_comb begin
        deb_cnt_d = '0;
        clean_d   = clean_q;
        // Any cycle that agrees with the clean level restarts qualification.
        if (sync_q[1] != clean_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                clean_d = ~clean_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end

        // Pulses are registered alongside the level so they line up with
        // the first cycle the new level is visible.
        rise_d = clean_d & ~clean_q;
        fall_d = ~clean_d & clean_q;

        stk_cnt_d = stk_cnt_q;
        stuck_d   = stuck_q;
        if (fault_clr_i) begin
            // Clear has priority over a coincident set.
            stk_cnt_d = '0;
            stuck_d   = 1'b0;
        end else begin
            if (!clean_q) begin
                stk_cnt_d = '0;
            end else if (stk_cnt_q != STUCK_MAX) begin
                stk_cnt_d = stk_cnt_q + 1'b1;
            end
            stuck_d = stuck_q | (stk_cnt_d == STUCK_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            deb_cnt_q <= '0;
            clean_q   <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            stk_cnt_q <= '0;
            stuck_q   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], raw_i};
            deb_cnt_q <= deb_cnt_d;
            clean_q   <= clean_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            stk_cnt_q <= stk_cnt_d;
            stuck_q   <= stuck_d;
        end
    end

    assign clean_o = clean_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign stuck_o = stuck_q;
endmodule

module sensor_debounce #(
    parameter int DEB_CYCLES   = 16,
    parameter int DEB_W        = 5,
    parameter int STUCK_CYCLES = 1000000,
    parameter int STUCK_W      = 20
) (
    input  logic                clk,
    input  logic                reset,
    sensor_debounce_if.slave    bus
);
    // lane 0 = outer beam a, lane 1 = inner beam b
    localparam int NUM_LANES = 2;

    logic [NUM_LANES-1:0] raw;
    logic [NUM_LANES-1:0] clean;
    logic [NUM_LANES-1:0] rise;
    logic [NUM_LANES-1:0] fall;
    logic [NUM_LANES-1:0] stuck;

    assign raw = {bus.b_raw, bus.a_raw};

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        sensor_debounce_ch #(
            .DEB_CYCLES   (DEB_CYCLES),
            .DEB_W        (DEB_W),
            .STUCK_CYCLES (STUCK_CYCLES),
            .STUCK_W      (STUCK_W)
        ) u_ch (
            .clk         (clk),
            .rst_n       (reset),
            .raw_i       (raw[l]),
            .fault_clr_i (bus.fault_clr),
            .clean_o     (clean[l]),
            .rise_o      (rise[l]),
            .fall_o      (fall[l]),
            .stuck_o     (stuck[l])
        );
    end

    assign bus.a       = clean[0];
    assign bus.b       = clean[1];
    assign bus.a_rise  = rise[0];
    assign bus.a_fall  = fall[0];
    assign bus.b_rise  = rise[1];
    assign bus.b_fall  = fall[1];
    assign bus.a_stuck = stuck[0];
    assign bus.b_stuck = stuck[1];
endmodule

// File: tb/tb_sensor_debounce.sv
// ---------------------------------------------------------------------------
// tb_sensor_debounce
//   Self-checking bench for sensor_debounce with DEB_CYCLES=4, STUCK_CYCLES=20.
//   The reference model states the rules directly: a channel's clean level
//   flips once the last DEB synchronised samples (raw delayed two edges) all
//   disagree with it; the stuck flag sets after STK consecutive edges of
//   clean=1 since the last clear or 0.
// ---------------------------------------------------------------------------
module tb_sensor_debounce;
    localparam int DEB = 4;
    localparam int STK = 20;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    sensor_debounce_if bus ();

    sensor_debounce #(
        .DEB_CYCLES   (DEB),
        .DEB_W        (3),
        .STUCK_CYCLES (STK),
        .STUCK_W      (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DEB+1:0] m_hist [2];
    logic           m_clean [2];
    logic           m_rise [2];
    logic           m_fall [2];
    logic           m_stuck [2];
    int             m_run [2];

    task automatic mdl_reset();
        for (int c = 0; c < 2; c++) begin
            m_hist[c]  = '0;
            m_clean[c] = 1'b0;
            m_rise[c]  = 1'b0;
            m_fall[c]  = 1'b0;
            m_stuck[c] = 1'b0;
            m_run[c]   = 0;
        end
    endtask

    task automatic mdl_edge(input logic ra, input logic rb, input logic clr);
        logic           r [2];
        logic           old;
        logic [DEB-1:0] win;
        r[0] = ra;
        r[1] = rb;
        for (int c = 0; c < 2; c++) begin
            old = m_clean[c];
            m_hist[c] = {m_hist[c][DEB:0], r[c]};
            win = m_hist[c][DEB+1:2];
            if (win == {DEB{~old}}) m_clean[c] = ~old;
            m_rise[c] = m_clean[c] & ~old;
            m_fall[c] = ~m_clean[c] & old;
            if (clr) begin
                m_run[c]   = 0;
                m_stuck[c] = 1'b0;
            end else begin
                m_run[c] = old ? ((m_run[c] < STK) ? m_run[c] + 1 : STK) : 0;
                if (m_run[c] == STK) m_stuck[c] = 1'b1;
            end
        end
    endtask

    function automatic logic [7:0] mdl_vec();
        return {m_clean[0], m_clean[1], m_rise[0], m_fall[0],
                m_rise[1], m_fall[1], m_stuck[0], m_stuck[1]};
    endfunction

    function automatic logic [7:0] dut_vec();
        return {bus.a, bus.b, bus.a_rise, bus.a_fall,
                bus.b_rise, bus.b_fall, bus.a_stuck, bus.b_stuck};
    endfunction

    // Drive inputs, take one rising edge, advance the model, settle 1ns.
    task automatic step(input logic ra, input logic rb, input logic clr);
        bus.a_raw     = ra;
        bus.b_raw     = rb;
        bus.fault_clr = clr;
        @(posedge clk);
        if (!reset) mdl_reset();
        else        mdl_edge(ra, rb, clr);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int rise_at, nrise, nfall;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b0);
            checks++;
            if (dut_vec() !== 8'h00) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, dut_vec(), 8'h00);
            end
        end
        reset = 1'b1;
        rise_at = 0; nrise = 0; nfall = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 1'b1, 1'b0);
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                failures++;
                $display("FAIL reset_release cyc=%0d got=%b exp=%b", i, dut_vec(), mdl_vec());
            end
            if (bus.a === 1'b1 && rise_at == 0) rise_at = i;
            if (bus.a_rise === 1'b1) nrise++;
            if (bus.a_fall === 1'b1) nfall++;
        end
        checks++;
        if (rise_at != 6) begin
            failures++;
            $display("FAIL reset_rise_latency got=%0d exp=6", rise_at);
        end
        checks++;
        if (nrise != 1 || nfall != 0) begin
            failures++;
            $display("FAIL reset_pulses rise=%0d fall=%0d exp rise=1 fall=0", nrise, nfall);
        end
    endtask

    task automatic test_glitch();
        int seen, npulse, rise_at, fall_at, nfall;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
        seen = 0; npulse = 0;
        for (int i = 1; i <= 13; i++) begin
            step(i <= 3, 1'b0, 1'b0);
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                failures++;
                $display("FAIL glitch3 cyc=%0d got=%b exp=%b", i, dut_vec(), mdl_vec());
            end
            if (bus.a === 1'b1) seen++;
            if (bus.a_rise === 1'b1 || bus.a_fall === 1'b1) npulse++;
        end
        checks++;
        if (seen != 0 || npulse != 0) begin
            failures++;
            $display("FAIL glitch3_reject a_high=%0d pulses=%0d exp 0 0", seen, npulse);
        end
        rise_at = 0; fall_at = 0; nfall = 0;
        for (int i = 1; i <= 16; i++) begin
            step(i <= 4, 1'b0, 1'b0);
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                failures++;
                $display("FAIL glitch4 cyc=%0d got=%b exp=%b", i, dut_vec(), mdl_vec());
            end
            if (bus.a === 1'b1 && rise_at == 0) rise_at = i;
            if (bus.a_fall === 1'b1) begin
                nfall++;
                fall_at = i;
            end
        end
        checks++;
        if (rise_at != 6 || fall_at != 10 || nfall != 1) begin
            failures++;
            $display("FAIL glitch4_accept rise=%0d fall=%0d nfall=%0d exp 6 10 1",
                     rise_at, fall_at, nfall);
        end
    endtask

    task automatic test_chatter();
        int seen, rise_at;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step(((i / 2) % 2) == 0, 1'b0, 1'b0);
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                failures++;
                $display("FAIL chatter cyc=%0d got=%b exp=%b", i, dut_vec(), mdl_vec());
            end
            if (bus.a === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL chatter_reject a_high=%0d exp 0", seen);
        end
        rise_at = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (bus.a === 1'b1 && rise_at == 0) rise_at = i;
        end
        checks++;
        if (rise_at != 6) begin
            failures++;
            $display("FAIL chatter_settle rise=%0d exp=6", rise_at);
        end
    endtask

    task automatic test_independent();
        int ar, br, af, bf;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
        ar = 0; br = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 1'b1, 1'b0);
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                failures++;
                $display("FAIL indep_rise cyc=%0d got=%b exp=%b", i, dut_vec(), mdl_vec());
            end
            if (bus.a_rise === 1'b1) ar = i;
            if (bus.b_rise === 1'b1) br = i;
        end
        checks++;
        if (ar != 6 || br != 6) begin
            failures++;
            $display("FAIL indep_same_cycle a_rise=%0d b_rise=%0d exp 6 6", ar, br);
        end
        af = 0; bf = 0;
        for (int i = 1; i <= 12; i++) begin
            step(i <= 2, 1'b0, 1'b0);
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                failures++;
                $display("FAIL indep_fall cyc=%0d got=%b exp=%b", i, dut_vec(), mdl_vec());
            end
            if (bus.a_fall === 1'b1) af = i;
            if (bus.b_fall === 1'b1) bf = i;
        end
        checks++;
        if (bf != 6 || af != 8) begin
            failures++;
            $display("FAIL indep_stagger b_fall=%0d a_fall=%0d exp 6 8", bf, af);
        end
    endtask

    task automatic test_stuck();
        int rise_at, stuck_at, dropped;
        rise_at = 0; stuck_at = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1'b1, 1'b0, 1'b0);
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                failures++;
                $display("FAIL stuck_hold cyc=%0d got=%b exp=%b", i, dut_vec(), mdl_vec());
            end
            if (bus.a === 1'b1 && rise_at == 0) rise_at = i;
            if (bus.a_stuck === 1'b1 && stuck_at == 0) stuck_at = i;
        end
        checks++;
        if (rise_at != 6 || stuck_at != 26) begin
            failures++;
            $display("FAIL stuck_set rise=%0d stuck=%0d exp 6 26", rise_at, stuck_at);
        end
        dropped = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (bus.a_stuck !== 1'b1) dropped++;
        end
        checks++;
        if (dropped != 0 || bus.a !== 1'b0) begin
            failures++;
            $display("FAIL stuck_sticky dropped=%0d a=%b exp 0 0", dropped, bus.a);
        end
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.a_stuck !== 1'b0) begin
            failures++;
            $display("FAIL stuck_clear got=%b exp=0", bus.a_stuck);
        end
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        checks++;
        if (bus.a_stuck !== 1'b0 || bus.a !== 1'b1) begin
            failures++;
            $display("FAIL stuck_clear_high stuck=%b a=%b exp 0 1", bus.a_stuck, bus.a);
        end
        stuck_at = 0;
        for (int i = 1; i <= 25; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (bus.a_stuck === 1'b1 && stuck_at == 0) stuck_at = i;
        end
        checks++;
        if (stuck_at != 20) begin
            failures++;
            $display("FAIL stuck_reassert got=%0d exp=20", stuck_at);
        end
        // clear lands on the very edge the flag would set again
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 19; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        checks++;
        if (bus.a_stuck !== 1'b0) begin
            failures++;
            $display("FAIL stuck_clear_wins got=%b exp=0", bus.a_stuck);
        end
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 1'b0, 1'b0);
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                failures++;
                $display("FAIL stuck_after_wins cyc=%0d got=%b exp=%b", i, dut_vec(), mdl_vec());
            end
        end
        // leave a low with its flag still set and b settled high
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0);
        checks++;
        if (dut_vec() !== 8'b01000010) begin
            failures++;
            $display("FAIL stuck_leave got=%b exp=%b", dut_vec(), 8'b01000010);
        end
    endtask

    task automatic test_reset_mid();
        int rise_at;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        mdl_reset();
        checks++;
        if (dut_vec() !== 8'h00) begin
            failures++;
            $display("FAIL reset_async got=%b exp=%b", dut_vec(), 8'h00);
        end
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        rise_at = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 1'b1, 1'b0);
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                failures++;
                $display("FAIL reset_mid cyc=%0d got=%b exp=%b", i, dut_vec(), mdl_vec());
            end
            if (bus.a === 1'b1 && rise_at == 0) rise_at = i;
        end
        checks++;
        if (rise_at != 6) begin
            failures++;
            $display("FAIL reset_mid_restart rise=%0d exp=6", rise_at);
        end
    endtask

    task automatic test_random();
        logic ra, rb, clr;
        int   ca, cb;
        ra = 1'b0; rb = 1'b0; ca = 0; cb = 0;
        for (int i = 0; i < 800; i++) begin
            if (ca == 0) begin
                ra = ~ra;
                ca = $urandom_range(1, 9);
            end
            if (cb == 0) begin
                rb = ~rb;
                cb = ($urandom_range(0, 9) == 0) ? $urandom_range(20, 40) : $urandom_range(1, 9);
            end
            ca--;
            cb--;
            clr = ($urandom_range(0, 39) == 0);
            step(ra, rb, clr);
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                failures++;
                $display("FAIL random cyc=%0d got=%b exp=%b", i, dut_vec(), mdl_vec());
            end
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b0;
        bus.a_raw     = 1'b0;
        bus.b_raw     = 1'b0;
        bus.fault_clr = 1'b0;
        mdl_reset();
        test_reset();
        test_glitch();
        test_chatter();
        test_independent();
        test_stuck();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
